// File: rtl/fetch_stage_pkg.sv
// Shared IF-stage constants and types: memory map, CP0 exception codes,
// the IF/ID payload record and the fetch-address legality check.
package fetch_stage_pkg;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] IM_BASE   = 32'h0000_3000;
    localparam logic [31:0] IM_LIMIT  = 32'h0000_6FFC;

    // CP0 Cause.ExcCode values, shared with CP0 and the later pipeline registers
    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    typedef enum logic [2:0] {
        NPC_EXC,
        NPC_ERET,
        NPC_HOLD,
        NPC_REDIRECT,
        NPC_SEQ
    } npc_src_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        exc;
        logic [4:0]  exc_code;
        logic        bd;
    } if_id_t;

    function automatic logic fetch_addr_bad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr < IM_BASE) || (addr > IM_LIMIT);
    endfunction

    // A flushed slot carries no instruction and no fault, only the PC it refers to.
    function automatic if_id_t if_id_bubble(input logic [31:0] pc);
        if_id_t b;
        b.instr    = 32'h0000_0000;
        b.pc       = pc;
        b.exc      = 1'b0;
        b.exc_code = EXC_INT;
        b.bd       = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load when enabled, bubble on flush, hold otherwise.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en,
    input  logic        i_flush,
    input  logic [31:0] i_flush_pc,
    input  if_id_t      i_d,
    output if_id_t      o_q
);

    if_id_t r_q;

    // Flush wins over a disabled register so exception/eret can bypass a stall.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_q <= if_id_bubble(PC_RESET);
        end else if (i_flush) begin
            r_q <= if_id_bubble(i_flush_pc);
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, next-PC priority selection, fetch-address
// checking and the IF/ID register feeding decode.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_npc_sel,
    input  logic [31:0] i_npc_target,
    input  logic        i_id_is_jump,
    input  logic        i_exc_req,
    input  logic        i_eret_req,
    input  logic [31:0] i_epc,
    input  logic [31:0] i_instr_f,
    output logic [31:0] o_pc_f,
    output logic [31:0] o_instr_d,
    output logic [31:0] o_pc_d,
    output logic        o_exc_d,
    output logic [4:0]  o_exc_code_d,
    output logic        o_bd_d
);

    logic [31:0] r_pc;
    npc_src_e    w_npc_src;
    logic [31:0] w_pc_next;
    logic        w_bad;
    logic        w_flush;
    logic [31:0] w_flush_pc;
    if_id_t      w_fetch;
    if_id_t      w_if_id;

    always_comb begin
        if (i_exc_req) begin
            w_npc_src = NPC_EXC;
        end else if (i_eret_req) begin
            w_npc_src = NPC_ERET;
        end else if (i_stall) begin
            w_npc_src = NPC_HOLD;
        end else if (i_npc_sel) begin
            w_npc_src = NPC_REDIRECT;
        end else begin
            w_npc_src = NPC_SEQ;
        end
    end

    // Sequential increment wraps modulo 2^32; the wrapped PC is caught by the checker.
    always_comb begin
        case (w_npc_src)
            NPC_EXC:      w_pc_next = EXC_ENTRY;
            NPC_ERET:     w_pc_next = i_epc;
            NPC_HOLD:     w_pc_next = r_pc;
            NPC_REDIRECT: w_pc_next = i_npc_target;
            NPC_SEQ:      w_pc_next = r_pc + 32'd4;
            default:      w_pc_next = r_pc + 32'd4;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc <= PC_RESET;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign w_bad = fetch_addr_bad(r_pc);

    // A bad fetch becomes a flagged nop; CP0 raises AdEL when it reaches M.
    always_comb begin
        w_fetch.pc = r_pc;
        w_fetch.bd = i_id_is_jump;
        if (w_bad) begin
            w_fetch.instr    = 32'h0000_0000;
            w_fetch.exc      = 1'b1;
            w_fetch.exc_code = EXC_ADEL;
        end else begin
            w_fetch.instr    = i_instr_f;
            w_fetch.exc      = 1'b0;
            w_fetch.exc_code = EXC_INT;
        end
    end

    assign w_flush    = i_exc_req | i_eret_req;
    assign w_flush_pc = i_exc_req ? EXC_ENTRY : i_epc;

    fetch_stage_if_id_reg u_if_id (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_en       (~i_stall),
        .i_flush    (w_flush),
        .i_flush_pc (w_flush_pc),
        .i_d        (w_fetch),
        .o_q        (w_if_id)
    );

    assign o_pc_f       = r_pc;
    assign o_instr_d    = w_if_id.instr;
    assign o_pc_d       = w_if_id.pc;
    assign o_exc_d      = w_if_id.exc;
    assign o_exc_code_d = w_if_id.exc_code;
    assign o_bd_d       = w_if_id.bd;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, mid-stream reset, then
// random control traffic checked against an abstract IF-stage model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, stall, npc_sel, id_is_jump, exc_req, eret_req;
    logic [31:0] npc_target, epc, instr_f;
    logic [31:0] pc_f, instr_d, pc_d;
    logic        exc_d, bd_d;
    logic [4:0]  exc_code_d;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_stall      (stall),
        .i_npc_sel    (npc_sel),
        .i_npc_target (npc_target),
        .i_id_is_jump (id_is_jump),
        .i_exc_req    (exc_req),
        .i_eret_req   (eret_req),
        .i_epc        (epc),
        .i_instr_f    (instr_f),
        .o_pc_f       (pc_f),
        .o_instr_d    (instr_d),
        .o_pc_d       (pc_d),
        .o_exc_d      (exc_d),
        .o_exc_code_d (exc_code_d),
        .o_bd_d       (bd_d)
    );

    function automatic logic fetch_ok(input logic [31:0] a);
        return (a % 4 == 0) && (a >= 32'h3000) && (a <= 32'h6FFC);
    endfunction

    // Legal words are tagged with their index; anything else is garbage the DUT must drop.
    function automatic logic [31:0] im_word(input logic [31:0] a);
        if (fetch_ok(a)) return 32'hA500_0000 + (a - 32'h3000) / 4;
        return 32'hDEAD_BEEF;
    endfunction

    assign instr_f = im_word(pc_f);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pcf, input logic [31:0] e_pcd,
                           input logic [31:0] e_instr, input logic e_exc, input logic [4:0] e_code,
                           input logic e_bd);
        chk({tag, ".pc_f"},       pc_f,       e_pcf);
        chk({tag, ".pc_d"},       pc_d,       e_pcd);
        chk({tag, ".instr_d"},    instr_d,    e_instr);
        chk({tag, ".exc_d"},      {31'd0, exc_d}, {31'd0, e_exc});
        chk({tag, ".exc_code_d"}, {27'd0, exc_code_d}, {27'd0, e_code});
        chk({tag, ".bd_d"},       {31'd0, bd_d}, {31'd0, e_bd});
    endtask

    task automatic drive(input logic s, input logic n, input logic [31:0] t, input logic j,
                         input logic e, input logic r, input logic [31:0] ep);
        stall = s; npc_sel = n; npc_target = t; id_is_jump = j;
        exc_req = e; eret_req = r; epc = ep;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        stall, npc, jump, exc, eret;
        logic [31:0] target, epc;
        logic [31:0] e_pcf, e_pcd, e_instr;
        logic        e_exc, e_bd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic s, input logic n, input logic [31:0] t, input logic j,
                                input logic e, input logic r, input logic [31:0] ep,
                                input logic [31:0] pcf, input logic [31:0] pcd,
                                input logic [31:0] ins, input logic ex, input logic bd);
        vec_t v;
        v.stall = s; v.npc = n; v.target = t; v.jump = j; v.exc = e; v.eret = r; v.epc = ep;
        v.e_pcf = pcf; v.e_pcd = pcd; v.e_instr = ins; v.e_exc = ex; v.e_bd = bd;
        return v;
    endfunction

    logic [31:0] m_pc, m_pcd, m_instr;
    logic        m_exc, m_bd;
    logic [4:0]  m_code;

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0: return 32'h3000 + 4 * $urandom_range(0, 4095) + $urandom_range(1, 3);
            1: return 32'h3000 - 4 * $urandom_range(1, 64);
            2: return 32'h7000 + 4 * $urandom_range(0, 64);
            3: return 32'hFFFF_FFFC;
            default: return 32'h3000 + 4 * $urandom_range(0, 4095);
        endcase
    endfunction

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;

        // two reset cycles, then release
        tick();
        chk_all("reset1", 32'h3000, 32'h3000, 0, 0, 0, 0);
        tick();
        chk_all("reset2", 32'h3000, 32'h3000, 0, 0, 0, 0);
        reset = 1'b0;

        //          s  n  target        j  e  r  epc           pc_f          pc_d          instr                exc bd
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,            32'h3004,     32'h3000,     im_word(32'h3000), 0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,            32'h3008,     32'h3004,     im_word(32'h3004), 0, 0));
        tbl.push_back(mk(1, 0, 0,            0, 0, 0, 0,            32'h3008,     32'h3004,     im_word(32'h3004), 0, 0));
        tbl.push_back(mk(1, 1, 32'h3500,     1, 0, 0, 0,            32'h3008,     32'h3004,     im_word(32'h3004), 0, 0));
        tbl.push_back(mk(1, 0, 0,            0, 0, 0, 0,            32'h3008,     32'h3004,     im_word(32'h3004), 0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,            32'h300C,     32'h3008,     im_word(32'h3008), 0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,            32'h3010,     32'h300C,     im_word(32'h300C), 0, 0));
        tbl.push_back(mk(0, 1, 32'h3100,     1, 0, 0, 0,            32'h3100,     32'h3010,     im_word(32'h3010), 0, 1));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,            32'h3104,     32'h3100,     im_word(32'h3100), 0, 0));
        tbl.push_back(mk(0, 1, 32'h3020,     0, 0, 0, 0,            32'h3020,     32'h3104,     im_word(32'h3104), 0, 0));
        tbl.push_back(mk(1, 1, 32'h3300,     1, 1, 0, 0,            32'h4180,     32'h4180,     0,                 0, 0));
        tbl.push_back(mk(1, 0, 0,            0, 0, 1, 32'h3022,     32'h3022,     32'h3022,     0,                 0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,            32'h3026,     32'h3022,     0,                 1, 0));
        tbl.push_back(mk(0, 1, 32'h3400,     0, 1, 1, 32'h5000,     32'h4180,     32'h4180,     0,                 0, 0));
        tbl.push_back(mk(0, 1, 32'h7000,     1, 0, 0, 0,            32'h7000,     32'h4180,     im_word(32'h4180), 0, 1));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,            32'h7004,     32'h7000,     0,                 1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 1, 32'h6FFC,     32'h6FFC,     32'h6FFC,     0,                 0, 0));
        tbl.push_back(mk(0, 0, 0,            1, 0, 0, 0,            32'h7000,     32'h6FFC,     im_word(32'h6FFC), 0, 1));
        tbl.push_back(mk(0, 0, 0,            0, 0, 1, 32'h2FFC,     32'h2FFC,     32'h2FFC,     0,                 0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,            32'h3000,     32'h2FFC,     0,                 1, 0));
        tbl.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0,           32'hFFFF_FFFC, 32'h3000,    im_word(32'h3000), 0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,            32'h0000_0000, 32'hFFFF_FFFC, 0,               1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,            32'h0000_0004, 32'h0000_0000, 0,               1, 0));
        tbl.push_back(mk(1, 1, 32'h3200,     0, 0, 0, 0,            32'h0000_0004, 32'h0000_0000, 0,               1, 0));
        tbl.push_back(mk(1, 0, 0,            0, 0, 1, 32'h3300,     32'h3300,     32'h3300,     0,                 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].stall, tbl[i].npc, tbl[i].target, tbl[i].jump,
                  tbl[i].exc, tbl[i].eret, tbl[i].epc);
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].e_pcf, tbl[i].e_pcd, tbl[i].e_instr,
                    tbl[i].e_exc, tbl[i].e_exc ? 5'd4 : 5'd0, tbl[i].e_bd);
        end

        // reset mid-stream with every control active: nothing else may land
        drive(1, 1, 32'h3800, 1, 1, 1, 32'h3900);
        reset = 1'b1;
        tick();
        chk_all("midreset", 32'h3000, 32'h3000, 0, 0, 0, 0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);

        m_pc = 32'h3000; m_pcd = 32'h3000; m_instr = 0; m_exc = 0; m_code = 0; m_bd = 0;
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, rand_addr(),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 15) == 0, rand_addr());
            if (exc_req || eret_req) begin
                m_pc    = exc_req ? 32'h4180 : epc;
                m_pcd   = m_pc;
                m_instr = 0; m_exc = 0; m_code = 0; m_bd = 0;
            end else if (!stall) begin
                m_pcd   = m_pc;
                m_bd    = id_is_jump;
                m_exc   = !fetch_ok(m_pc);
                m_code  = m_exc ? 5'd4 : 5'd0;
                m_instr = m_exc ? 32'd0 : im_word(m_pc);
                m_pc    = npc_sel ? npc_target : m_pc + 32'd4;
            end
            tick();
            chk_all($sformatf("rand%0d", c), m_pc, m_pcd, m_instr, m_exc, m_code, m_bd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
